stream_mux_n: RTL
=================

// Module: stream_mux_n
// PURPOSE
//  Parametrised N:1 stream multiplexer with a valid/ready handshake and packet locking.
//  Selects one input channel either statically (sel) or by round-robin arbitration.
//  Holds the grant until the channel's last beat, through a registered output stage.
//  Merges pixel/line streams from several image sources into one downstream consumer.
// PARAMETERS
//  WIDTH  8  data bits per channel
//  N      4  number of input channels (>=2); localparam SEL_W = $clog2(N)
// PORTS
//  clk        in   1        system clock, all state on rising edge
//  rst_n      in   1        asynchronous reset, active-low
//  in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N        per-channel beat valid
//  in_last    in   N        per-channel end-of-packet flag, qualified by in_valid
//  in_ready   out  N        per-channel beat accepted when in_valid[i] & in_ready[i]
//  mode       in   1        0 = static select, 1 = round-robin
//  sel        in   SEL_W    static channel index, used only when mode=0
//  out_data   out  WIDTH    registered output data
//  out_valid  out  1        output beat valid
//  out_last   out  1        output end-of-packet flag
//  out_ch     out  SEL_W    source channel of the current output beat
//  out_ready  in   1        downstream accept
//  busy       out  1        1 while a packet is locked (state LOCKED)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, out_last=0, out_data=0, out_ch=0,
//    busy=0, in_ready=0, rr_ptr=N-1. A mid-packet reset drops the packet; no beats resume.
//  Output slot free: slot_free = !out_valid | out_ready.
//  FSM IDLE: mode and sel are sampled only here.
//    mode=0: candidate = sel if sel<N and in_valid[sel]; sel>=N -> no grant, ever.
//    mode=1: candidate = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ...
//      and wrapping modulo N.
//    With a candidate: cur=candidate (combinational) and in_ready[cur]=slot_free.
//      If the beat is accepted and in_last=0, go to LOCKED; if in_last=1, stay in IDLE.
//      Either way, rr_ptr <= cur on the first accepted beat.
//  FSM LOCKED: cur is held in a register; in_ready[cur]=slot_free; all other in_ready=0.
//    mode/sel changes are ignored. Accepting a beat with in_last=1 returns the FSM to IDLE.
//  Back-to-back packets: the next packet's first beat can be accepted on the cycle after
//    the previous packet's last beat. There is no bubble while out_ready=1.
//  Output register: on an accept, out_data/out_last/out_ch <= the selected beat and
//    out_valid <= 1. Otherwise, if out_ready, out_valid <= 0. Latency is 1 cycle.
//    Throughput is 1 beat/cycle.
//  Backpressure: while out_valid & !out_ready, all in_ready=0 and the output is stable.
//  Never more than one in_ready bit high. in_ready depends combinationally on in_valid
//    only in IDLE.
// CONFIGURATION
//  MUX_BEAT_CNT_EN defined:
//    adds output beat_cnt [15:0], reset to 0;
//    loads 1 on the first beat of a packet and increments on each later accepted beat;
//    saturates at 16'hFFFF and holds its value after the last beat until the next packet.
//  MUX_BEAT_CNT_EN undefined:
//    no beat_cnt port and no counter logic; all other behaviour is identical.
// TESTING
//  1. Static: mode=0, sel=2; ch2 sends 3 beats (AA,BB,CC, last on CC) while ch0 is also
//     valid; out_ready=1 -> out_data AA,BB,CC on cycles 1..3 with out_ch=2, out_last on CC;
//     in_ready[0] stays 0 throughout.
//  2. Round-robin: mode=1, ch0..ch3 each send a 1-beat packet continuously from reset
//     -> out_ch sequence 0,1,2,3,0,... with no idle cycles.
//  3. Lock: mode=1; ch1 starts a 4-beat packet; ch0 and ch3 assert valid mid-packet; sel
//     and mode toggle -> all 4 ch1 beats are contiguous; then ch3 is granted, then ch0.
//  4. Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data/out_last/out_ch are
//     stable, in_ready=0 for all channels; no beat lost or duplicated after release.
//  5. Edges: mode=0, sel=N (N non-power-of-2, e.g. N=3, sel=3) -> no grant, out_valid
//     stays 0. Reset asserted mid-packet -> outputs reset immediately; after release
//     the FSM is in IDLE and arbitration starts from ch0.
//  6. MUX_BEAT_CNT_EN: 3-beat packet -> beat_cnt 1,2,3 and holds 3; a 70000-beat packet
//     -> beat_cnt saturates at 65535.

Source files
------------

// File: rtl/stream_mux_n.sv
// ----------------------------------------------------------------------------
// stream_mux_n
//   N:1 valid/ready stream multiplexer with packet locking and a registered
//   output stage. The channel is chosen in IDLE either statically (sel) or by
//   round-robin. The grant is then held until that channel's last beat.
//
// Parameters
//   WIDTH  data bits per channel
//   N      number of input channels (>=2)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/valid/last  per-channel beats, channel i at [i*WIDTH +: WIDTH]
//   in_ready            per-channel accept (at most one bit high)
//   mode, sel           0 = static select on sel, 1 = round-robin (IDLE only)
//   out_data/valid/last registered output beat
//   out_ch              source channel of the output beat
//   out_ready           downstream accept
//   busy                high while a packet is locked
//   beat_cnt            beats of the current/last packet, saturating
//                       (present only with MUX_BEAT_CNT_EN defined)
//
// Optional feature macro: MUX_BEAT_CNT_EN
// ----------------------------------------------------------------------------
module stream_mux_n #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_ch,
    input  logic               out_ready,
    output logic               busy
`ifdef MUX_BEAT_CNT_EN
    ,
    output logic [15:0]        beat_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;

    logic [SEL_W-1:0]   cand;
    logic               cand_hit;
    logic [SEL_W-1:0]   cur;
    logic               grant_en;
    logic [N-1:0]       gnt;
    logic               slot_free;
    logic               accept;
    logic [WIDTH-1:0]   acc_data;
    logic               acc_last;

    // Candidate selection, only meaningful in IDLE.
    // Static: the loop only matches indices below N, so an out-of-range sel
    // never produces a grant. Round-robin: walk distances N..1 from rr_ptr so
    // the nearest valid channel after rr_ptr is the last (winning) assignment.
    always_comb begin
        cand     = '0;
        cand_hit = 1'b0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (SEL_W'(i) == sel && in_valid[i]) begin
                    cand     = SEL_W'(i);
                    cand_hit = 1'b1;
                end
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                for (int i = 0; i < N; i++) begin
                    if (i == (int'(rr_ptr_q) + k) % N && in_valid[i]) begin
                        cand     = SEL_W'(i);
                        cand_hit = 1'b1;
                    end
                end
            end
        end
    end

    // Grant vector and beat acceptance. Reset gates the handshake so no
    // in_ready can rise combinationally from in_valid while rst_n is low.
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        cur       = (state_q == LOCKED) ? cur_q : cand;
        grant_en  = rst_n && ((state_q == LOCKED) || cand_hit);
        acc_data  = '0;
        acc_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = grant_en && (cur == SEL_W'(i));
            if (gnt[i]) begin
                acc_data = in_data[i*WIDTH +: WIDTH];
                acc_last = in_last[i];
            end
        end
        accept = slot_free && |(gnt & in_valid);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            rr_ptr_q <= SEL_W'(N - 1);
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // FSM: next state. rr_ptr and the locked channel move only on the first
    // beat of a packet, which is always accepted in IDLE.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (state_q == IDLE) begin
                cur_d    = cur;
                rr_ptr_d = cur;
            end
            state_d = acc_last ? IDLE : LOCKED;
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready = slot_free ? gnt : '0;
        busy     = (state_q == LOCKED);
    end

    // Output register stage
    always_comb begin
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = acc_data;
            out_last_d  = acc_last;
            out_ch_d    = cur;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

`ifdef MUX_BEAT_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    // First beat of a packet loads 1; later beats count up and saturate.
    // Value holds after the last beat until the next packet starts.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            if (state_q == IDLE)
                beat_cnt_d = 16'd1;
            else if (beat_cnt_q != 16'hFFFF)
                beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beat_cnt_q <= '0;
        else        beat_cnt_q <= beat_cnt_d;
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
